// File: rtl/iob_bus_merge.sv
// rtl/iob_bus_merge.sv - merges instruction and data buses onto one native memory port
// One outstanding transaction; winning request is registered, response strobe steered back.
module iob_bus_merge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                m_valid,
  output logic                m_instr,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q;
  logic                last_data_q;
  logic                m_valid_q;
  logic                m_instr_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic [DATA_W/8-1:0] m_wstrb_q;

  logic grant_instr;
  logic done;

  // Instruction wins when alone, or on a tie in round-robin mode after a data grant.
  always_comb begin
    grant_instr = i_valid && (!d_valid || ((FIXED_PRIO == 0) && last_data_q));
  end

  // Gating with resetn drops the in-flight response during a synchronous reset.
  assign done    = (state_q == BUSY) && m_ready && resetn;
  assign i_ready = done && m_instr_q;
  assign d_ready = done && !m_instr_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  assign m_valid = m_valid_q;
  assign m_instr = m_instr_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_data_q <= 1'b1;
      m_valid_q   <= 1'b0;
      m_instr_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
    end else if (state_q == IDLE) begin
      if (i_valid || d_valid) begin
        state_q   <= BUSY;
        m_valid_q <= 1'b1;
        m_instr_q <= grant_instr;
        m_addr_q  <= grant_instr ? i_addr : d_addr;
        m_wdata_q <= grant_instr ? '0 : d_wdata;
        m_wstrb_q <= grant_instr ? '0 : d_wstrb;
      end
    end else begin
      if (m_ready) begin
        state_q     <= IDLE;
        m_valid_q   <= 1'b0;
        last_data_q <= !m_instr_q;
      end
    end
  end

endmodule
